ras_ckpt: RTL and testbench
===========================

Name: ras_ckpt

Overview:
- Parametrised return address stack (RAS) for the fetch predictors, with checkpoint restore.
- Generalises the fixed 8-entry RAS: any depth (power of two or not) and any target width.
- Supports push, pop, and a combined push+pop (replace top) in one cycle.
- Restores to a checkpointed (index, count) on mispredict; a push/pop in the same cycle is applied on top of the restored state.
- Sits beside the BTB/UPCT in the fetch predictor cluster. Prediction read is combinational from the current top.

Parameters:
- RAS_ENTRIES, 8, stack depth; any value >= 2.
- RAS_INDEX_WIDTH, $clog2(RAS_ENTRIES), width of the top pointer.
- RAS_COUNT_WIDTH, $clog2(RAS_ENTRIES+1), width of the valid-entry count.
- RAS_TARGET_WIDTH, 31, return target width (PC[31:1]).

Ports:
- CLK  input  1  clock
- nRST  input  1  reset, asynchronous, active-low
- push_valid  input  1  call detected; push push_target
- push_target  input  RAS_TARGET_WIDTH  return address to push
- pop_valid  input  1  return detected; pop top
- restore_valid  input  1  load checkpointed pointer and count
- restore_index  input  RAS_INDEX_WIDTH  checkpointed top pointer
- restore_count  input  RAS_COUNT_WIDTH  checkpointed valid count
- ret_target  output  RAS_TARGET_WIDTH  array[top], combinational
- ret_valid  output  1  count != 0
- ras_index  output  RAS_INDEX_WIDTH  current top pointer, for checkpointing
- ras_count  output  RAS_COUNT_WIDTH  current valid count, for checkpointing
- ras_full  output  1  count == RAS_ENTRIES

Behaviour:
- Interface: one clock CLK; reset nRST is asynchronous and active-low.
- Reset: top=0, count=0, all array entries 0. Hence ret_target=0, ret_valid=0, ras_index=0, ras_count=0, ras_full=0.
- State: circular array[RAS_ENTRIES], top pointer, count. All updates take effect at the next CLK edge; outputs reflect registered state.
- Pointer arithmetic: inc(p) = (p==RAS_ENTRIES-1) ? 0 : p+1; dec(p) = (p==0) ? RAS_ENTRIES-1 : p-1. Explicit compares, never bit truncation, so non-power-of-2 depths wrap correctly.
- Base state: if restore_valid, (top', count') = (restore_index, min(restore_count, RAS_ENTRIES)); otherwise the current (top, count).
  - restore_index >= RAS_ENTRIES is illegal input; the assertion fires and the index is taken modulo by a single subtract.
- Operation on the base state:
  - Push only:
    - array[inc(top')] <= push_target; top <= inc(top'); count <= min(count'+1, RAS_ENTRIES).
    - Overflow silently overwrites the oldest entry.
  - Pop only:
    - If count' > 0: top <= dec(top'); count <= count'-1.
    - If count' == 0 (underflow): top <= top'; count <= 0; array untouched.
  - Push+pop:
    - array[top'] <= push_target; top <= top'.
    - count <= count' if count' > 0, else 1.
  - Neither: top <= top'; count <= count'.
- Restore never modifies array contents. Entries beyond the checkpoint may have been overwritten since; this is accepted predictor inaccuracy.
- ret_target is array[top] even when count==0 (stale value). Consumers must gate on ret_valid.
- Write priority: the same-cycle read of ret_target sees pre-update contents. No bypass.
- No handshake or backpressure: every asserted input is consumed in its cycle.
- Reset asserted mid-operation clears all state immediately, regardless of CLK.

Decomposition:
- RAS_ENTRIES, RAS_INDEX_WIDTH and RAS_TARGET_WIDTH already exist in core_types_pkg. Add RAS_COUNT_WIDTH there.
- Module parameters default to the package values.
- Single module. No sub-module is natural; inc/dec are local functions.
- Array implemented as flops (small depth); no SRAM macro.

Test Plan:
1. Reset, then 3 pushes 0x100, 0x200, 0x300 -> ras_index=3, ras_count=3, ret_target=0x300. Then 3 pops -> ret_target 0x200, then 0x100, then ret_valid=0, ras_index=0.
2. N=8: 10 pushes 0x1..0xA -> ras_count=8, ras_full=1, ras_index=2, ret_target=0xA. Then 8 pops return 0xA..0x3 in order, then ret_valid=0. A 9th pop -> count stays 0, ras_index unchanged.
3. Push+pop with count=2, top=0x20 -> ret_target=0x55, ras_count=2, ras_index unchanged. Push+pop when empty -> ras_count=1.
4. Checkpoint (index=4, count=4), then 3 pushes and 1 pop, then restore_valid with (4, 4) -> ras_index=4, ras_count=4. Restore with pop same cycle -> ras_index=3, ras_count=3.
5. RAS_ENTRIES=6: 7 pushes from reset -> ras_index wraps 5->0->1, ras_count=6. Pop at index 0 -> ras_index=5.
6. Assert nRST low asynchronously mid-stream with count=5 -> all outputs 0 before the next CLK edge.

Source files
------------

// File: rtl/core_types_pkg.sv
// rtl/core_types_pkg.sv - shared fetch-predictor sizing constants
package core_types_pkg;

    localparam int RAS_ENTRIES      = 8;
    localparam int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES);
    localparam int RAS_COUNT_WIDTH  = $clog2(RAS_ENTRIES + 1);
    localparam int RAS_TARGET_WIDTH = 31;

endpackage

// File: rtl/ras_ckpt.sv
// rtl/ras_ckpt.sv - circular return address stack with checkpoint restore
module ras_ckpt #(
    parameter int RAS_ENTRIES      = core_types_pkg::RAS_ENTRIES,
    parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
    parameter int RAS_COUNT_WIDTH  = $clog2(RAS_ENTRIES + 1),
    parameter int RAS_TARGET_WIDTH = core_types_pkg::RAS_TARGET_WIDTH
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        push_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] push_target,
    input  logic                        pop_valid,
    input  logic                        restore_valid,
    input  logic [RAS_INDEX_WIDTH-1:0]  restore_index,
    input  logic [RAS_COUNT_WIDTH-1:0]  restore_count,
    output logic [RAS_TARGET_WIDTH-1:0] ret_target,
    output logic                        ret_valid,
    output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
    output logic [RAS_COUNT_WIDTH-1:0]  ras_count,
    output logic                        ras_full
);

    localparam logic [RAS_COUNT_WIDTH-1:0] ENTRIES_C = RAS_COUNT_WIDTH'(RAS_ENTRIES);
    localparam logic [RAS_INDEX_WIDTH-1:0] LAST_IDX  = RAS_INDEX_WIDTH'(RAS_ENTRIES - 1);

    logic [RAS_TARGET_WIDTH-1:0] ras_mem [RAS_ENTRIES];
    logic [RAS_INDEX_WIDTH-1:0]  top, top_nxt, base_top, wr_idx;
    logic [RAS_COUNT_WIDTH-1:0]  count, count_nxt, base_count, idx_ext;
    logic                        wr_en;

    // Explicit wrap compares so non-power-of-two depths stay inside the array.
    function automatic logic [RAS_INDEX_WIDTH-1:0] ptr_inc(input logic [RAS_INDEX_WIDTH-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [RAS_INDEX_WIDTH-1:0] ptr_dec(input logic [RAS_INDEX_WIDTH-1:0] p);
        return (p == '0) ? LAST_IDX : p - 1'b1;
    endfunction

    assign idx_ext = RAS_COUNT_WIDTH'(restore_index);

    always_comb begin
        base_top   = top;
        base_count = count;
        if (restore_valid) begin
            // Out-of-range checkpoints are illegal; fold them once so the pointer stays addressable.
            base_top   = (idx_ext >= ENTRIES_C) ? RAS_INDEX_WIDTH'(idx_ext - ENTRIES_C) : restore_index;
            base_count = (restore_count > ENTRIES_C) ? ENTRIES_C : restore_count;
        end

        top_nxt   = base_top;
        count_nxt = base_count;
        wr_en     = 1'b0;
        wr_idx    = base_top;

        unique case ({push_valid, pop_valid})
            2'b10: begin
                wr_en     = 1'b1;
                wr_idx    = ptr_inc(base_top);
                top_nxt   = ptr_inc(base_top);
                count_nxt = (base_count == ENTRIES_C) ? ENTRIES_C : base_count + 1'b1;
            end
            2'b01: begin
                if (base_count != '0) begin
                    top_nxt   = ptr_dec(base_top);
                    count_nxt = base_count - 1'b1;
                end
            end
            2'b11: begin
                // Replace top: the call and return cancel in depth.
                wr_en     = 1'b1;
                wr_idx    = base_top;
                count_nxt = (base_count == '0) ? RAS_COUNT_WIDTH'(1) : base_count;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            top   <= '0;
            count <= '0;
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            top   <= top_nxt;
            count <= count_nxt;
            if (wr_en) begin
                ras_mem[wr_idx] <= push_target;
            end
        end
    end

    // Read is from registered state only; a same-cycle push is not bypassed.
    assign ret_target = ras_mem[top];
    assign ret_valid  = (count != '0);
    assign ras_index  = top;
    assign ras_count  = count;
    assign ras_full   = (count == ENTRIES_C);

    restore_index_in_range: assert property (
        @(posedge CLK) disable iff (!nRST) restore_valid |-> (idx_ext < ENTRIES_C)
    );

endmodule

// File: tb/tb_ras_ckpt.sv
// tb/tb_ras_ckpt.sv - directed table-driven bench for ras_ckpt
module tb_ras_ckpt;

    logic        clk;
    logic        rst_n;

    logic        push8, pop8, rv8;
    logic [30:0] tgt8;
    logic [2:0]  ridx8;
    logic [3:0]  rcnt8;
    logic [30:0] ret_tgt8;
    logic        ret_v8, full8;
    logic [2:0]  idx8;
    logic [3:0]  cnt8;

    logic        push6, pop6, rv6;
    logic [30:0] tgt6;
    logic [2:0]  ridx6;
    logic [2:0]  rcnt6;
    logic [30:0] ret_tgt6;
    logic        ret_v6, full6;
    logic [2:0]  idx6;
    logic [2:0]  cnt6;

    int n_tests = 0;
    int n_fail  = 0;

    ras_ckpt u_dut8 (
        .CLK(clk), .nRST(rst_n),
        .push_valid(push8), .push_target(tgt8), .pop_valid(pop8),
        .restore_valid(rv8), .restore_index(ridx8), .restore_count(rcnt8),
        .ret_target(ret_tgt8), .ret_valid(ret_v8), .ras_index(idx8),
        .ras_count(cnt8), .ras_full(full8)
    );

    ras_ckpt #(
        .RAS_ENTRIES(6), .RAS_INDEX_WIDTH(3), .RAS_COUNT_WIDTH(3), .RAS_TARGET_WIDTH(31)
    ) u_dut6 (
        .CLK(clk), .nRST(rst_n),
        .push_valid(push6), .push_target(tgt6), .pop_valid(pop6),
        .restore_valid(rv6), .restore_index(ridx6), .restore_count(rcnt6),
        .ret_target(ret_tgt6), .ret_valid(ret_v6), .ras_index(idx6),
        .ras_count(cnt6), .ras_full(full6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic [30:0] tgt;
        logic        pop;
        logic        rv;
        logic [2:0]  ridx;
        logic [3:0]  rcnt;
        logic [30:0] e_tgt;
        logic        e_valid;
        logic [2:0]  e_idx;
        logic [3:0]  e_cnt;
        logic        e_full;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic push, input logic [30:0] tgt, input logic pop,
                       input logic rv, input logic [2:0] ridx, input logic [3:0] rcnt,
                       input logic [30:0] e_tgt, input logic e_valid, input logic [2:0] e_idx,
                       input logic [3:0] e_cnt, input logic e_full);
        vec_t v;
        v.push = push; v.tgt = tgt; v.pop = pop; v.rv = rv; v.ridx = ridx; v.rcnt = rcnt;
        v.e_tgt = e_tgt; v.e_valid = e_valid; v.e_idx = e_idx; v.e_cnt = e_cnt; v.e_full = e_full;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [30:0] t, input logic v,
                        input logic [2:0] i, input logic [3:0] c, input logic f);
        chk({tag, ".ret_target"}, {1'b0, ret_tgt8}, {1'b0, t});
        chk({tag, ".ret_valid"},  {31'b0, ret_v8},  {31'b0, v});
        chk({tag, ".ras_index"},  {29'b0, idx8},    {29'b0, i});
        chk({tag, ".ras_count"},  {28'b0, cnt8},    {28'b0, c});
        chk({tag, ".ras_full"},   {31'b0, full8},   {31'b0, f});
    endtask

    task automatic idle8();
        push8 = 1'b0; pop8 = 1'b0; rv8 = 1'b0; tgt8 = '0; ridx8 = '0; rcnt8 = '0;
    endtask

    initial begin
        idle8();
        push6 = 1'b0; pop6 = 1'b0; rv6 = 1'b0; tgt6 = '0; ridx6 = '0; rcnt6 = '0;
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        step();
        chk8("reset8", 31'h0, 1'b0, 3'd0, 4'd0, 1'b0);
        chk("reset6.ras_count", {29'b0, cnt6}, 32'd0);

        // Basic push / pop
        add(1, 31'h100, 0, 0, 0, 0, 31'h100, 1, 1, 1, 0);
        add(1, 31'h200, 0, 0, 0, 0, 31'h200, 1, 2, 2, 0);
        add(1, 31'h300, 0, 0, 0, 0, 31'h300, 1, 3, 3, 0);
        add(0, 31'h0,   1, 0, 0, 0, 31'h200, 1, 2, 2, 0);
        add(0, 31'h0,   1, 0, 0, 0, 31'h100, 1, 1, 1, 0);
        add(0, 31'h0,   1, 0, 0, 0, 31'h0,   0, 0, 0, 0);
        // Overflow: 10 pushes into 8 entries
        for (int k = 1; k <= 10; k++) begin
            add(1, 31'(k), 0, 0, 0, 0, 31'(k), 1, 3'(k % 8),
                (k > 8) ? 4'd8 : 4'(k), (k >= 8) ? 1'b1 : 1'b0);
        end
        add(0, 0, 1, 0, 0, 0, 31'h9, 1, 1, 7, 0);
        add(0, 0, 1, 0, 0, 0, 31'h8, 1, 0, 6, 0);
        add(0, 0, 1, 0, 0, 0, 31'h7, 1, 7, 5, 0);
        add(0, 0, 1, 0, 0, 0, 31'h6, 1, 6, 4, 0);
        add(0, 0, 1, 0, 0, 0, 31'h5, 1, 5, 3, 0);
        add(0, 0, 1, 0, 0, 0, 31'h4, 1, 4, 2, 0);
        add(0, 0, 1, 0, 0, 0, 31'h3, 1, 3, 1, 0);
        add(0, 0, 1, 0, 0, 0, 31'hA, 0, 2, 0, 0);
        add(0, 0, 1, 0, 0, 0, 31'hA, 0, 2, 0, 0);
        // Replace top, then replace on empty
        add(1, 31'h10, 0, 0, 0, 0, 31'h10, 1, 3, 1, 0);
        add(1, 31'h20, 0, 0, 0, 0, 31'h20, 1, 4, 2, 0);
        add(1, 31'h55, 1, 0, 0, 0, 31'h55, 1, 4, 2, 0);
        add(0, 0,      1, 0, 0, 0, 31'h10, 1, 3, 1, 0);
        add(0, 0,      1, 0, 0, 0, 31'hA,  0, 2, 0, 0);
        add(1, 31'h66, 1, 0, 0, 0, 31'h66, 1, 2, 1, 0);
        // Checkpoint restore
        add(0, 0,      0, 1, 4, 4, 31'h55, 1, 4, 4, 0);
        add(1, 31'h71, 0, 0, 0, 0, 31'h71, 1, 5, 5, 0);
        add(1, 31'h72, 0, 0, 0, 0, 31'h72, 1, 6, 6, 0);
        add(1, 31'h73, 0, 0, 0, 0, 31'h73, 1, 7, 7, 0);
        add(0, 0,      1, 0, 0, 0, 31'h72, 1, 6, 6, 0);
        add(0, 0,      0, 1, 4, 4, 31'h55, 1, 4, 4, 0);
        add(0, 0,      1, 1, 4, 4, 31'h10, 1, 3, 3, 0);
        add(0, 0,      0, 1, 1, 15, 31'h9, 1, 1, 8, 1);
        add(1, 31'h77, 0, 1, 0, 0, 31'h77, 1, 1, 1, 0);

        foreach (vecs[n]) begin
            push8 = vecs[n].push; tgt8 = vecs[n].tgt; pop8 = vecs[n].pop;
            rv8 = vecs[n].rv; ridx8 = vecs[n].ridx; rcnt8 = vecs[n].rcnt;
            step();
            chk8($sformatf("vec%0d", n), vecs[n].e_tgt, vecs[n].e_valid,
                 vecs[n].e_idx, vecs[n].e_cnt, vecs[n].e_full);
        end
        idle8();

        // Same-cycle read sees pre-update contents (state: top=1 holding 0x77)
        push8 = 1'b1; pop8 = 1'b1; tgt8 = 31'h99;
        #1;
        chk("nobypass.ret_target", {1'b0, ret_tgt8}, 32'h77);
        step();
        chk("replace.ret_target", {1'b0, ret_tgt8}, 32'h99);
        idle8();

        // Async reset mid-cycle with count=5
        rv8 = 1'b1; ridx8 = 3'd3; rcnt8 = 4'd5;
        step();
        idle8();
        chk("prereset.ras_count", {28'b0, cnt8}, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk8("asyncrst", 31'h0, 1'b0, 3'd0, 4'd0, 1'b0);
        #2;
        rst_n = 1'b1;

        // Depth 6 wrap
        for (int k = 1; k <= 7; k++) begin
            push6 = 1'b1; tgt6 = 31'(32'h10 + k);
            step();
            chk($sformatf("d6push%0d.ras_index", k), {29'b0, idx6}, 32'(k % 6));
            chk($sformatf("d6push%0d.ras_count", k), {29'b0, cnt6}, (k > 6) ? 32'd6 : 32'(k));
            chk($sformatf("d6push%0d.ret_target", k), {1'b0, ret_tgt6}, 32'(32'h10 + k));
        end
        chk("d6.ras_full", {31'b0, full6}, 32'd1);
        push6 = 1'b0; pop6 = 1'b1;
        step();
        chk("d6pop1.ras_index", {29'b0, idx6}, 32'd0);
        chk("d6pop1.ret_target", {1'b0, ret_tgt6}, 32'h16);
        step();
        chk("d6pop2.ras_index", {29'b0, idx6}, 32'd5);
        chk("d6pop2.ras_count", {29'b0, cnt6}, 32'd4);
        chk("d6pop2.ret_target", {1'b0, ret_tgt6}, 32'h15);
        pop6 = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
